// File: rtl/mem_bus_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_sequencer_pkg
// Purpose  : Shared definitions for the two-requester memory bus sequencer.
//            Holds the sequencer state encoding, requester side constants
//            and the fixed address/data widths of the shared RAM port.
// Revision : 1.0 - initial release
// ============================================================================
package mem_bus_sequencer_pkg;

    // Fixed widths of the shared memory port and requester data path
    localparam int ADDR_W = 20;
    localparam int BYTE_W = 8;
    localparam int WORD_W = 16;

    // Requester identifiers (also the encoding of last_b)
    localparam logic SIDE_A = 1'b0;
    localparam logic SIDE_B = 1'b1;

    // Sequencer states: one IDLE/arbitration cycle, low byte, optional
    // high byte, then a finish cycle that collects the last read byte.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_FIN  = 2'd3
    } seq_state_e;

endpackage
`default_nettype wire

// File: rtl/mem_bus_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_sequencer
// Purpose  : Shares one 8-bit synchronous RAM port between requester A
//            (CPU core) and requester B (DMA/video agent). Round-robin
//            arbitration, little-endian byte/word reads and writes, word
//            accesses split into two byte cycles.
// Ports    :
//   clock, reset           - clock (posedge), async active-high reset
//   a_req/b_req            - request, held until the matching ack
//   a_addr/b_addr [19:0]   - byte address of the first (low) byte
//   a_wdata/b_wdata [15:0] - write data, byte writes use [7:0]
//   a_we/b_we              - 1 = write, 0 = read
//   a_bit16/b_bit16        - 1 = word access, 0 = byte access
//   a_ack/b_ack            - one-cycle completion pulse
//   rdata [15:0]           - read result, valid in the ack cycle
//   busy                   - sequencer not idle
//   last_b                 - most recent grant went to B
//   mem_address [19:0]     - RAM address
//   mem_in [7:0]           - RAM read data (one cycle after address)
//   mem_out [7:0]          - RAM write data
//   mem_wren               - RAM write enable
// Revision : 1.0 - initial release
// ============================================================================
module mem_bus_sequencer
    import mem_bus_sequencer_pkg::*;
(
    input  logic              clock,
    input  logic              reset,

    input  logic              a_req,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [WORD_W-1:0] a_wdata,
    input  logic              a_we,
    input  logic              a_bit16,
    output logic              a_ack,

    input  logic              b_req,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [WORD_W-1:0] b_wdata,
    input  logic              b_we,
    input  logic              b_bit16,
    output logic              b_ack,

    output logic [WORD_W-1:0] rdata,
    output logic              busy,
    output logic              last_b,

    output logic [ADDR_W-1:0] mem_address,
    input  logic [BYTE_W-1:0] mem_in,
    output logic [BYTE_W-1:0] mem_out,
    output logic              mem_wren
);

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    seq_state_e        r_state;
    logic              r_side;
    logic [ADDR_W-1:0] r_addr;
    logic [WORD_W-1:0] r_wdata;
    logic              r_we;
    logic              r_bit16;
    logic              r_a_ack;
    logic              r_b_ack;
    logic [WORD_W-1:0] r_rdata;
    logic              r_busy;
    logic              r_last_b;
    logic [ADDR_W-1:0] r_mem_address;
    logic [BYTE_W-1:0] r_mem_out;
    logic              r_mem_wren;

    // ------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------
    seq_state_e        w_state_nxt;
    logic              w_side_nxt;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [WORD_W-1:0] w_wdata_nxt;
    logic              w_we_nxt;
    logic              w_bit16_nxt;
    logic              w_a_ack_nxt;
    logic              w_b_ack_nxt;
    logic [WORD_W-1:0] w_rdata_nxt;
    logic              w_busy_nxt;
    logic              w_last_b_nxt;
    logic [ADDR_W-1:0] w_mem_address_nxt;
    logic [BYTE_W-1:0] w_mem_out_nxt;
    logic              w_mem_wren_nxt;

    // Arbitration result and the selected requester's fields
    logic              w_grant;
    logic              w_pick;
    logic [ADDR_W-1:0] w_req_addr;
    logic [WORD_W-1:0] w_req_wdata;
    logic              w_req_we;
    logic              w_req_bit16;

    // ------------------------------------------------------------------
    // State register (all outputs come straight from these flops)
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_side        <= SIDE_A;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_we          <= 1'b0;
            r_bit16       <= 1'b0;
            r_a_ack       <= 1'b0;
            r_b_ack       <= 1'b0;
            r_rdata       <= '0;
            r_busy        <= 1'b0;
            // Starting as "B went last" gives A the first tie.
            r_last_b      <= SIDE_B;
            r_mem_address <= '0;
            r_mem_out     <= '0;
            r_mem_wren    <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_side        <= w_side_nxt;
            r_addr        <= w_addr_nxt;
            r_wdata       <= w_wdata_nxt;
            r_we          <= w_we_nxt;
            r_bit16       <= w_bit16_nxt;
            r_a_ack       <= w_a_ack_nxt;
            r_b_ack       <= w_b_ack_nxt;
            r_rdata       <= w_rdata_nxt;
            r_busy        <= w_busy_nxt;
            r_last_b      <= w_last_b_nxt;
            r_mem_address <= w_mem_address_nxt;
            r_mem_out     <= w_mem_out_nxt;
            r_mem_wren    <= w_mem_wren_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt       = r_state;
        w_side_nxt        = r_side;
        w_addr_nxt        = r_addr;
        w_wdata_nxt       = r_wdata;
        w_we_nxt          = r_we;
        w_bit16_nxt       = r_bit16;
        w_a_ack_nxt       = 1'b0;
        w_b_ack_nxt       = 1'b0;
        w_rdata_nxt       = r_rdata;
        w_last_b_nxt      = r_last_b;
        w_mem_address_nxt = r_mem_address;
        w_mem_out_nxt     = r_mem_out;
        w_mem_wren_nxt    = 1'b0;     // write enable only lives for one state
        w_grant           = 1'b0;
        w_pick            = SIDE_A;
        w_req_addr        = a_addr;
        w_req_wdata       = a_wdata;
        w_req_we          = a_we;
        w_req_bit16       = a_bit16;

        case (r_state)
            ST_IDLE: begin
                // In the ack cycle the finished requester still holds req;
                // arbitrating now would replay its access.
                if (!(r_a_ack || r_b_ack)) begin
                    w_grant = a_req | b_req;
                    if (a_req && b_req) begin
                        w_pick = ~r_last_b;
                    end else begin
                        w_pick = b_req ? SIDE_B : SIDE_A;
                    end
                end

                if (w_pick == SIDE_B) begin
                    w_req_addr  = b_addr;
                    w_req_wdata = b_wdata;
                    w_req_we    = b_we;
                    w_req_bit16 = b_bit16;
                end

                if (w_grant) begin
                    w_side_nxt        = w_pick;
                    w_addr_nxt        = w_req_addr;
                    w_wdata_nxt       = w_req_wdata;
                    w_we_nxt          = w_req_we;
                    w_bit16_nxt       = w_req_bit16;
                    w_last_b_nxt      = w_pick;
                    w_mem_address_nxt = w_req_addr;
                    w_state_nxt       = ST_LO;
                    if (w_req_we) begin
                        w_mem_out_nxt  = w_req_wdata[7:0];
                        w_mem_wren_nxt = 1'b1;
                    end
                end
            end

            ST_LO: begin
                if (r_bit16) begin
                    // 20-bit add wraps 0xFFFFF to 0x00000 naturally
                    w_mem_address_nxt = r_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
                    w_state_nxt       = ST_HI;
                    if (r_we) begin
                        w_mem_out_nxt  = r_wdata[15:8];
                        w_mem_wren_nxt = 1'b1;
                    end
                end else begin
                    w_state_nxt = ST_FIN;
                end
            end

            ST_HI: begin
                // Low byte, addressed during LO, is on mem_in now
                if (!r_we) begin
                    w_rdata_nxt[7:0] = mem_in;
                end
                w_state_nxt = ST_FIN;
            end

            ST_FIN: begin
                if (!r_we) begin
                    if (r_bit16) begin
                        w_rdata_nxt[15:8] = mem_in;
                    end else begin
                        w_rdata_nxt = {{(WORD_W-BYTE_W){1'b0}}, mem_in};
                    end
                end
                if (r_side == SIDE_B) begin
                    w_b_ack_nxt = 1'b1;
                end else begin
                    w_a_ack_nxt = 1'b1;
                end
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign a_ack       = r_a_ack;
    assign b_ack       = r_b_ack;
    assign rdata       = r_rdata;
    assign busy        = r_busy;
    assign last_b      = r_last_b;
    assign mem_address = r_mem_address;
    assign mem_out     = r_mem_out;
    assign mem_wren    = r_mem_wren;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_bus_sequencer
// Purpose  : Scoreboard bench for mem_bus_sequencer. Stimulus builds an
//            ordered list of expected completions from a transaction-level
//            model (round-robin order, access latencies, a byte-array
//            memory); a monitor pops one entry per observed ack.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_bus_sequencer;
    import mem_bus_sequencer_pkg::*;

    typedef struct {
        logic        we;
        logic        bit16;
        logic [19:0] addr;
        logic [15:0] wdata;
    } op_t;

    typedef struct {
        logic        side;
        logic [15:0] rdata;
        int          wren;
        int          cyc;
    } exp_t;

    // DUT signals
    logic        clock   = 1'b0;
    logic        reset   = 1'b1;
    logic        a_req   = 1'b0;
    logic [19:0] a_addr  = '0;
    logic [15:0] a_wdata = '0;
    logic        a_we    = 1'b0;
    logic        a_bit16 = 1'b0;
    logic        a_ack;
    logic        b_req   = 1'b0;
    logic [19:0] b_addr  = '0;
    logic [15:0] b_wdata = '0;
    logic        b_we    = 1'b0;
    logic        b_bit16 = 1'b0;
    logic        b_ack;
    logic [15:0] rdata;
    logic        busy;
    logic        last_b;
    logic [19:0] mem_address;
    logic [7:0]  mem_in = '0;
    logic [7:0]  mem_out;
    logic        mem_wren;

    mem_bus_sequencer dut (
        .clock       (clock),
        .reset       (reset),
        .a_req       (a_req),
        .a_addr      (a_addr),
        .a_wdata     (a_wdata),
        .a_we        (a_we),
        .a_bit16     (a_bit16),
        .a_ack       (a_ack),
        .b_req       (b_req),
        .b_addr      (b_addr),
        .b_wdata     (b_wdata),
        .b_we        (b_we),
        .b_bit16     (b_bit16),
        .b_ack       (b_ack),
        .rdata       (rdata),
        .busy        (busy),
        .last_b      (last_b),
        .mem_address (mem_address),
        .mem_in      (mem_in),
        .mem_out     (mem_out),
        .mem_wren    (mem_wren)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc = cyc + 1;

    // Synchronous RAM: read data appears the cycle after the address
    logic [7:0] ram     [0:1048575];
    logic [7:0] ref_mem [0:1048575];
    always @(posedge clock) begin
        mem_in <= ram[mem_address];
        if (mem_wren) ram[mem_address] = mem_out;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_event(input string name, input string detail);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: %s (cycle %0d)", name, detail, cyc);
    endtask

    // ------------------------------------------------------------------
    // Transaction-level reference model
    // ------------------------------------------------------------------
    logic        m_last  = 1'b1;   // side served most recently
    logic [15:0] m_rdata = '0;     // value rdata holds after the access
    exp_t        exp_q[$];

    function automatic logic [7:0] init_byte(input logic [19:0] a);
        return a[7:0] ^ a[15:8] ^ {a[19:16], a[3:0]} ^ 8'h3C;
    endfunction

    function automatic logic [15:0] model_exec(input op_t op);
        logic [19:0] a_hi;
        a_hi = op.addr + 20'd1;
        if (op.we) begin
            ref_mem[op.addr] = op.wdata[7:0];
            if (op.bit16) ref_mem[a_hi] = op.wdata[15:8];
        end else if (op.bit16) begin
            m_rdata = {ref_mem[a_hi], ref_mem[op.addr]};
        end else begin
            m_rdata = {8'h00, ref_mem[op.addr]};
        end
        return m_rdata;
    endfunction

    function automatic op_t mk_op(input logic we, input logic b16,
                                  input logic [19:0] addr, input logic [15:0] wd);
        op_t o;
        o.we = we; o.bit16 = b16; o.addr = addr; o.wdata = wd;
        return o;
    endfunction

    function automatic op_t rand_op();
        logic [19:0] a;
        if ($urandom_range(0, 1) == 0) a = 20'($urandom_range(0, 31));
        else                           a = 20'hFFFE0 + 20'($urandom_range(0, 31));
        return mk_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, 16'($urandom));
    endfunction

    task automatic preload(input logic [19:0] a, input logic [7:0] v);
        ram[a]     = v;
        ref_mem[a] = v;
    endtask

    // ------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------
    int   wren_cnt = 0;
    exp_t mon_e;
    always @(negedge clock) begin
        if (reset) begin
            wren_cnt = 0;
            if (a_ack || b_ack) fail_event("ack_during_reset", "ack seen while reset high");
        end else begin
            if (mem_wren) wren_cnt++;
            if (a_ack && b_ack) begin
                fail_event("dual_ack", "a_ack and b_ack together");
            end else if (a_ack || b_ack) begin
                if (exp_q.size() == 0) begin
                    fail_event("unexpected_ack", b_ack ? "b_ack with nothing pending" : "a_ack with nothing pending");
                end else begin
                    mon_e = exp_q.pop_front();
                    check("ack_side",   b_ack,    mon_e.side);
                    check("ack_rdata",  rdata,    mon_e.rdata);
                    check("ack_cycle",  cyc,      mon_e.cyc);
                    check("wren_count", wren_cnt, mon_e.wren);
                    check("last_b",     last_b,   mon_e.side);
                    check("busy_ack",   busy,     1'b0);
                end
                wren_cnt = 0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Requester drivers
    // ------------------------------------------------------------------
    // Each op is raised #1 after a posedge, held through its ack cycle and
    // dropped right after the edge that ends the ack cycle.
    task automatic drive(input logic side, input op_t ops[$]);
        bit got;
        for (int k = 0; k < ops.size(); k++) begin
            if (k > 0) begin @(posedge clock); #1; end
            if (side) begin
                b_addr = ops[k].addr; b_wdata = ops[k].wdata;
                b_we = ops[k].we; b_bit16 = ops[k].bit16; b_req = 1'b1;
            end else begin
                a_addr = ops[k].addr; a_wdata = ops[k].wdata;
                a_we = ops[k].we; a_bit16 = ops[k].bit16; a_req = 1'b1;
            end
            got = 1'b0;
            for (int c = 0; c < 40 && !got; c++) begin
                @(negedge clock);
                got = side ? b_ack : a_ack;
            end
            if (!got) fail_event(side ? "b_ack_timeout" : "a_ack_timeout", "no ack within 40 cycles");
            @(posedge clock); #1;
            if (side) b_req = 1'b0; else a_req = 1'b0;
        end
    endtask

    // Predicts completion order and timing: both pending -> side opposite
    // the previous one; the next access starts the cycle after the ack, or
    // two cycles after when the same requester has to re-raise req.
    task automatic run_batch(input op_t aq[$], input op_t bq[$]);
        op_t  op;
        exp_t e;
        int   ai, bi, g, prev_ack;
        logic s, prev_side;
        bit   first;
        ai = 0; bi = 0; prev_ack = 0; prev_side = 1'b0; first = 1'b1;
        @(posedge clock); #1;
        g = cyc;
        while (ai < aq.size() || bi < bq.size()) begin
            if (ai < aq.size() && bi < bq.size()) s = ~m_last;
            else                                  s = (bi < bq.size());
            if (s) begin op = bq[bi]; bi++; end
            else   begin op = aq[ai]; ai++; end
            if (!first) g = (s == prev_side) ? prev_ack + 2 : prev_ack + 1;
            e.side  = s;
            e.rdata = model_exec(op);
            e.wren  = op.we ? (op.bit16 ? 2 : 1) : 0;
            e.cyc   = g + (op.bit16 ? 4 : 3);
            exp_q.push_back(e);
            m_last    = s;
            prev_side = s;
            prev_ack  = e.cyc;
            first     = 1'b0;
        end
        fork
            drive(1'b0, aq);
            drive(1'b1, bq);
        join
        repeat (3) @(posedge clock);
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    op_t qa[$];
    op_t qb[$];
    int  g_rst;
    bit  got_rst;

    initial begin
        for (int i = 0; i < 1048576; i++) begin
            ram[i]     = init_byte(20'(i));
            ref_mem[i] = ram[i];
        end

        // Reset values
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_mem_address", mem_address, 20'h0);
        check("rst_mem_out",     mem_out,     8'h0);
        check("rst_mem_wren",    mem_wren,    1'b0);
        check("rst_a_ack",       a_ack,       1'b0);
        check("rst_b_ack",       b_ack,       1'b0);
        check("rst_rdata",       rdata,       16'h0);
        check("rst_busy",        busy,        1'b0);
        check("rst_last_b",      last_b,      1'b1);
        @(posedge clock); #1;
        reset = 1'b0;

        // Both requesters stream byte reads: A,B,A,B,A,B
        qa.delete(); qb.delete();
        for (int i = 0; i < 3; i++) begin
            qa.push_back(mk_op(1'b0, 1'b0, 20'(i), 16'h0));
            qb.push_back(mk_op(1'b0, 1'b0, 20'(i + 8), 16'h0));
        end
        run_batch(qa, qb);

        // A byte read at 0x00010 returns 0x005A
        preload(20'h00010, 8'h5A);
        qa.delete(); qb.delete();
        qa.push_back(mk_op(1'b0, 1'b0, 20'h00010, 16'h0));
        run_batch(qa, qb);

        // A word write 0xBEEF at 0x12345
        qa.delete(); qb.delete();
        qa.push_back(mk_op(1'b1, 1'b1, 20'h12345, 16'hBEEF));
        run_batch(qa, qb);
        check("ram_12345", ram[20'h12345], 8'hEF);
        check("ram_12346", ram[20'h12346], 8'hBE);

        // B word read wrapping from 0xFFFFF to 0x00000 -> 0x1234
        preload(20'hFFFFF, 8'h34);
        preload(20'h00000, 8'h12);
        qa.delete(); qb.delete();
        qb.push_back(mk_op(1'b0, 1'b1, 20'hFFFFF, 16'h0));
        run_batch(qa, qb);

        // Reset during the HI cycle of a word write; held req restarts
        @(posedge clock); #1;
        a_addr = 20'h00040; a_wdata = 16'hC3A5; a_we = 1'b1; a_bit16 = 1'b1; a_req = 1'b1;
        @(posedge clock); @(posedge clock); #1;
        check("hi_wren_before_reset", mem_wren, 1'b1);
        reset = 1'b1;
        #1;
        check("reset_kills_wren",  mem_wren,    1'b0);
        check("reset_busy",        busy,        1'b0);
        check("reset_a_ack",       a_ack,       1'b0);
        check("reset_mem_address", mem_address, 20'h0);
        check("reset_last_b",      last_b,      1'b1);
        @(posedge clock); #1;
        reset = 1'b0;
        g_rst   = cyc;
        m_last  = 1'b1;
        m_rdata = 16'h0;
        begin
            exp_t e;
            e.side  = SIDE_A;
            e.rdata = model_exec(mk_op(1'b1, 1'b1, 20'h00040, 16'hC3A5));
            e.wren  = 2;
            e.cyc   = g_rst + 4;
            exp_q.push_back(e);
            m_last  = SIDE_A;
        end
        got_rst = 1'b0;
        for (int c = 0; c < 40 && !got_rst; c++) begin
            @(negedge clock);
            got_rst = a_ack;
        end
        if (!got_rst) fail_event("restart_ack_timeout", "no ack after reset release");
        @(posedge clock); #1;
        a_req = 1'b0;
        repeat (3) @(posedge clock);
        check("restart_ram_40", ram[20'h00040], 8'hA5);
        check("restart_ram_41", ram[20'h00041], 8'hC3);

        // Randomized batches
        for (int b = 0; b < 40; b++) begin
            int na, nb;
            na = $urandom_range(0, 3);
            nb = $urandom_range(0, 3);
            if (na + nb == 0) na = 1;
            qa.delete(); qb.delete();
            for (int i = 0; i < na; i++) qa.push_back(rand_op());
            for (int i = 0; i < nb; i++) qb.push_back(rand_op());
            run_batch(qa, qb);
        end

        // Final memory image in the exercised windows
        repeat (4) @(posedge clock);
        for (int i = 0; i < 64; i++) begin
            check("final_mem_lo", ram[20'(i)], ref_mem[20'(i)]);
            check("final_mem_hi", ram[20'hFFFC0 + 20'(i)], ref_mem[20'hFFFC0 + 20'(i)]);
        end
        check("scoreboard_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
